// File: rtl/posit_raw_adder_pipe.sv
// Four-stage elastic adder for decoded posit operands: select/compare, align+add,
// leading-one detect, normalise. A single global enable stalls every stage together.
module posit_raw_adder_pipe #(
    parameter int FRAC_W  = 60,
    parameter int SCALE_W = 9,
    parameter int GUARD_W = 3,
    parameter int IN_W    = FRAC_W + SCALE_W + 3,
    parameter int OUT_W   = FRAC_W + GUARD_W + SCALE_W + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    input  logic             in1_truncated,
    input  logic             in2_truncated,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             truncated
);
    localparam int MANT_W  = FRAC_W + GUARD_W + 1;
    localparam int SUM_W   = MANT_W + 1;
    localparam int OFRAC_W = FRAC_W + GUARD_W;
    localparam int DIFF_W  = SCALE_W + 1;
    localparam int LZ_W    = $clog2(MANT_W + 1);

    function automatic logic [LZ_W-1:0] count_lz(input logic [MANT_W-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (v[i]) n = LZ_W'(MANT_W - 1 - i);
        end
        return n;
    endfunction

    logic en;

    logic                      a_zero, b_zero, a_sgn, b_sgn, a_inf, b_inf, a_tr, b_tr, a_hi;
    logic signed [SCALE_W-1:0] a_scale, b_scale, lo_scale;
    logic [FRAC_W-1:0]         a_frac, b_frac;

    logic                      vld_p0_q, sgn_p0_d, sgn_p0_q, hi_zero_p0_d, hi_zero_p0_q;
    logic                      lo_zero_p0_d, lo_zero_p0_q, sub_p0_d, sub_p0_q;
    logic                      inf_p0_d, inf_p0_q, trunc_p0_d, trunc_p0_q;
    logic signed [SCALE_W-1:0] scale_p0_d, scale_p0_q;
    logic [FRAC_W-1:0]         hi_frac_p0_d, hi_frac_p0_q, lo_frac_p0_d, lo_frac_p0_q;
    logic [DIFF_W-1:0]         diff_p0_d, diff_p0_q;

    logic [MANT_W-1:0]         hi_m, lo_m, aligned;
    logic [2*MANT_W-1:0]       ext;
    logic                      shift_st;
    logic                      vld_p1_q, sgn_p1_q, inf_p1_q, sticky_p1_d, sticky_p1_q;
    logic signed [SCALE_W-1:0] scale_p1_q;
    logic [SUM_W-1:0]          sum_p1_d, sum_p1_q;

    logic                      vld_p2_q, sgn_p2_q, inf_p2_q, sticky_p2_q;
    logic signed [SCALE_W-1:0] scale_p2_q;
    logic [SUM_W-1:0]          sum_p2_q;
    logic [LZ_W-1:0]           lz_p2_d, lz_p2_q;

    logic [SCALE_W:0]          scale_ext, out_scale;
    logic [OFRAC_W-1:0]        out_frac;
    logic                      vld_p3_q, trunc_p3_d, trunc_p3_q;
    logic [OUT_W-1:0]          result_p3_d, result_p3_q;

    assign en        = ~vld_p3_q | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p3_q;
    assign result    = result_p3_q;
    assign truncated = trunc_p3_q;

    // Stage 0: mask zero operands, order by magnitude
    always_comb begin
        a_zero  = in1[0];
        b_zero  = in2[0];
        a_sgn   = in1[IN_W-1] & ~a_zero;
        b_sgn   = in2[IN_W-1] & ~b_zero;
        a_scale = a_zero ? '0 : in1[IN_W-2 -: SCALE_W];
        b_scale = b_zero ? '0 : in2[IN_W-2 -: SCALE_W];
        a_frac  = a_zero ? '0 : in1[FRAC_W+1:2];
        b_frac  = b_zero ? '0 : in2[FRAC_W+1:2];
        a_inf   = in1[1] & ~a_zero;
        b_inf   = in2[1] & ~b_zero;
        a_tr    = in1_truncated & ~a_zero;
        b_tr    = in2_truncated & ~b_zero;
        a_hi    = 1'b1;
        if (b_zero)                  a_hi = 1'b1;
        else if (a_zero)             a_hi = 1'b0;
        else if (a_scale != b_scale) a_hi = (a_scale > b_scale);
        else                         a_hi = (a_frac >= b_frac);
        sgn_p0_d     = a_hi ? a_sgn   : b_sgn;
        scale_p0_d   = a_hi ? a_scale : b_scale;
        lo_scale     = a_hi ? b_scale : a_scale;
        hi_frac_p0_d = a_hi ? a_frac  : b_frac;
        lo_frac_p0_d = a_hi ? b_frac  : a_frac;
        hi_zero_p0_d = a_hi ? a_zero  : b_zero;
        lo_zero_p0_d = a_hi ? b_zero  : a_zero;
        sub_p0_d     = a_sgn ^ b_sgn;
        diff_p0_d    = {scale_p0_d[SCALE_W-1], scale_p0_d} - {lo_scale[SCALE_W-1], lo_scale};
        inf_p0_d     = a_inf | b_inf;
        trunc_p0_d   = a_tr | b_tr;
    end

    // Stage 1: align lo to hi, collecting shifted-out bits, then add/subtract
    always_comb begin
        hi_m = {~hi_zero_p0_q, hi_frac_p0_q, {GUARD_W{1'b0}}};
        lo_m = {~lo_zero_p0_q, lo_frac_p0_q, {GUARD_W{1'b0}}};
        ext  = {lo_m, {MANT_W{1'b0}}} >> diff_p0_q;
        aligned  = ext[2*MANT_W-1:MANT_W];
        shift_st = |ext[MANT_W-1:0];
        if (diff_p0_q >= DIFF_W'(MANT_W)) begin
            aligned  = '0;
            shift_st = |lo_m;
        end
        sum_p1_d    = sub_p0_q ? ({1'b0, hi_m} - {1'b0, aligned}) : ({1'b0, hi_m} + {1'b0, aligned});
        sticky_p1_d = shift_st | trunc_p0_q;
    end

    // Stage 2: leading zeros below the carry bit
    assign lz_p2_d = count_lz(sum_p1_q[MANT_W-1:0]);

    // Stage 3: normalise and pack
    always_comb begin
        scale_ext  = {scale_p2_q[SCALE_W-1], scale_p2_q};
        out_scale  = scale_ext - {{(SCALE_W+1-LZ_W){1'b0}}, lz_p2_q};
        out_frac   = sum_p2_q[OFRAC_W-1:0] << lz_p2_q;
        trunc_p3_d = sticky_p2_q;
        if (sum_p2_q[SUM_W-1]) begin
            out_scale  = scale_ext + (SCALE_W+1)'(1);
            out_frac   = sum_p2_q[MANT_W-1:1];
            trunc_p3_d = sticky_p2_q | sum_p2_q[0];
        end
        result_p3_d = {sgn_p2_q, out_scale, out_frac, 2'b00};
        if (inf_p2_q) begin
            result_p3_d    = '0;
            result_p3_d[1] = 1'b1;
            trunc_p3_d     = 1'b0;
        end else if (sum_p2_q == '0) begin
            result_p3_d    = '0;
            result_p3_d[0] = 1'b1;
            trunc_p3_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            result_p3_q <= '0;
            trunc_p3_q  <= 1'b0;
        end else if (en) begin
            vld_p0_q     <= in_valid;
            sgn_p0_q     <= sgn_p0_d;
            scale_p0_q   <= scale_p0_d;
            hi_frac_p0_q <= hi_frac_p0_d;
            lo_frac_p0_q <= lo_frac_p0_d;
            hi_zero_p0_q <= hi_zero_p0_d;
            lo_zero_p0_q <= lo_zero_p0_d;
            sub_p0_q     <= sub_p0_d;
            diff_p0_q    <= diff_p0_d;
            inf_p0_q     <= inf_p0_d;
            trunc_p0_q   <= trunc_p0_d;

            vld_p1_q     <= vld_p0_q;
            sgn_p1_q     <= sgn_p0_q;
            scale_p1_q   <= scale_p0_q;
            inf_p1_q     <= inf_p0_q;
            sum_p1_q     <= sum_p1_d;
            sticky_p1_q  <= sticky_p1_d;

            vld_p2_q     <= vld_p1_q;
            sgn_p2_q     <= sgn_p1_q;
            scale_p2_q   <= scale_p1_q;
            inf_p2_q     <= inf_p1_q;
            sum_p2_q     <= sum_p1_q;
            sticky_p2_q  <= sticky_p1_q;
            lz_p2_q      <= lz_p2_d;

            vld_p3_q     <= vld_p2_q;
            result_p3_q  <= result_p3_d;
            trunc_p3_q   <= trunc_p3_d;
        end
    end
endmodule

// File: tb/tb_posit_raw_adder_pipe.sv
// Bench for posit_raw_adder_pipe: directed spec cases plus randomized traffic with
// backpressure, scored against a value-level reference model.
module tb_posit_raw_adder_pipe;
    localparam int FRAC_W  = 60;
    localparam int SCALE_W = 9;
    localparam int GUARD_W = 3;
    localparam int IN_W    = FRAC_W + SCALE_W + 3;
    localparam int OUT_W   = FRAC_W + GUARD_W + SCALE_W + 4;
    localparam int MANT_W  = FRAC_W + GUARD_W + 1;
    localparam int OFRAC_W = FRAC_W + GUARD_W;
    localparam logic [FRAC_W-1:0] F_HI  = 60'h123456789ABCDEF;
    localparam logic [FRAC_W-1:0] F_1P5 = 60'h800000000000000;
    localparam logic [FRAC_W-1:0] F_1P25 = 60'h400000000000000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in1 = '0;
    logic [IN_W-1:0]  in2 = '0;
    logic             in1_truncated = 1'b0;
    logic             in2_truncated = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] result;
    logic             truncated;

    int n_checks = 0;
    int n_errs   = 0;
    int n_pop    = 0;
    logic [OUT_W:0] exp_q[$];
    logic           stall_prev = 1'b0;
    logic [OUT_W+1:0] stall_word;
    logic           rand_done;

    posit_raw_adder_pipe #(
        .FRAC_W(FRAC_W), .SCALE_W(SCALE_W), .GUARD_W(GUARD_W), .IN_W(IN_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .in1_truncated(in1_truncated), .in2_truncated(in2_truncated),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .truncated(truncated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] mk_in(input logic s, input int e, input logic [FRAC_W-1:0] f,
                                             input logic inf, input logic z);
        return {s, SCALE_W'(e), f, inf, z};
    endfunction

    function automatic logic [OUT_W-1:0] mk_out(input logic s, input int e, input logic [OFRAC_W-1:0] f,
                                               input logic inf, input logic z);
        return {s, (SCALE_W+1)'(e), f, inf, z};
    endfunction

    // Value-level model: mantissas as integers, alignment by division-style truncation,
    // normalisation by repeated doubling/halving.
    function automatic logic [OUT_W:0] ref_add(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y,
                                              input logic tx, input logic ty);
        logic xs, ys, xi, yi, hs, x_hi, st;
        int xe, ye, he, le, d, e;
        logic [127:0] xm, ym, hm, lm, al, rem, sum, one;
        one = 128'(1);
        xs = x[IN_W-1]; ys = y[IN_W-1];
        xe = $signed(x[IN_W-2 -: SCALE_W]); ye = $signed(y[IN_W-2 -: SCALE_W]);
        xi = x[1]; yi = y[1];
        xm = (one << (MANT_W-1)) | (128'(x[FRAC_W+1:2]) << GUARD_W);
        ym = (one << (MANT_W-1)) | (128'(y[FRAC_W+1:2]) << GUARD_W);
        if (x[0]) begin xs = 0; xe = 0; xi = 0; xm = 0; tx = 0; end
        if (y[0]) begin ys = 0; ye = 0; yi = 0; ym = 0; ty = 0; end
        if (xi || yi) return {1'b0, mk_out(1'b0, 0, '0, 1'b1, 1'b0)};
        if (y[0])          x_hi = 1'b1;
        else if (x[0])     x_hi = 1'b0;
        else if (xe != ye) x_hi = (xe > ye);
        else               x_hi = (xm >= ym);
        hs = x_hi ? xs : ys;
        he = x_hi ? xe : ye;
        le = x_hi ? ye : xe;
        hm = x_hi ? xm : ym;
        lm = x_hi ? ym : xm;
        d = he - le;
        if (lm == 0)          begin al = 0; rem = 0; end
        else if (d >= MANT_W) begin al = 0; rem = lm; end
        else begin al = lm >> d; rem = lm - (al << d); end
        sum = (xs != ys) ? hm - al : hm + al;
        st = (rem != 0) | tx | ty;
        if (sum == 0) return {1'b0, mk_out(1'b0, 0, '0, 1'b0, 1'b1)};
        e = he;
        while (sum >= (one << MANT_W)) begin st |= sum[0]; sum = sum >> 1; e++; end
        while (sum < (one << (MANT_W-1))) begin sum = sum << 1; e--; end
        return {st, mk_out(hs, e, sum[OFRAC_W-1:0], 1'b0, 1'b0)};
    endfunction

    function automatic logic [IN_W-1:0] rand_op();
        int r, e;
        logic [FRAC_W-1:0] f;
        r = int'($urandom_range(0, 19));
        f = FRAC_W'({$urandom(), $urandom()});
        if (r < 3) f = FRAC_W'($urandom_range(0, 7)) << (FRAC_W-3);
        e = int'($urandom_range(0, 16)) - 8;
        if (r == 3) e = int'($urandom_range(0, 511)) - 256;
        if (r == 4) return mk_in(1'($urandom()), e, f, 1'($urandom()), 1'b1);
        if (r == 5) return mk_in(1'b0, 0, '0, 1'b1, 1'b0);
        return mk_in(1'($urandom()), e, f, 1'b0, 1'b0);
    endfunction

    // Scoreboard and handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (stall_prev) check("stall_hold", {out_valid, truncated, result}, stall_word);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
                else begin
                    check("result", {truncated, result}, exp_q.pop_front());
                    n_pop++;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_word = {out_valid, truncated, result};
            if (in_valid && in_ready) exp_q.push_back(ref_add(in1, in2, in1_truncated, in2_truncated));
        end
    end

    task automatic drive_pair(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                              input logic ta, input logic tb);
        int k;
        in1 = a; in2 = b; in1_truncated = ta; in2_truncated = tb; in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) check("in_ready_wait", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_dir(input string tag, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                            input logic ta, input logic tb, input logic [OUT_W-1:0] er, input logic et);
        int n;
        out_ready = 1'b1;
        in1 = a; in2 = b; in1_truncated = ta; in2_truncated = tb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check($sformatf("%s.lat", tag), n, 4);
        check($sformatf("%s.res", tag), result, er);
        check($sformatf("%s.tr", tag), truncated, et);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 200) begin @(posedge clk); #1; k++; end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [IN_W-1:0] one_p0, a, b;
        int pop0;
        one_p0 = mk_in(1'b0, 0, '0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.result", result, '0);
        check("rst.trunc", truncated, 1'b0);

        send_dir("one_plus_one", one_p0, one_p0, 1'b0, 1'b0, mk_out(1'b0, 1, '0, 1'b0, 1'b0), 1'b0);
        send_dir("cancel", mk_in(1'b0, 0, F_1P5, 1'b0, 1'b0), mk_in(1'b1, 0, F_1P5, 1'b0, 1'b0),
                 1'b0, 1'b0, mk_out(1'b0, 0, '0, 1'b0, 1'b1), 1'b0);
        send_dir("near_cancel", mk_in(1'b0, 0, F_1P5, 1'b0, 1'b0), mk_in(1'b1, 0, F_1P25, 1'b0, 1'b0),
                 1'b0, 1'b0, mk_out(1'b0, -2, '0, 1'b0, 1'b0), 1'b0);
        send_dir("far", mk_in(1'b0, 100, F_HI, 1'b0, 1'b0), mk_in(1'b0, -100, 60'h5, 1'b0, 1'b0),
                 1'b0, 1'b0, mk_out(1'b0, 100, {F_HI, 3'b000}, 1'b0, 1'b0), 1'b1);
        send_dir("edge_shift", mk_in(1'b0, 100, F_HI, 1'b0, 1'b0),
                 mk_in(1'b0, 100 - (FRAC_W + GUARD_W), 60'h1, 1'b0, 1'b0),
                 1'b0, 1'b0, mk_out(1'b0, 100, {F_HI, 3'b001}, 1'b0, 1'b0), 1'b1);
        send_dir("inf", mk_in(1'b0, 0, '0, 1'b1, 1'b0), one_p0, 1'b1, 1'b0,
                 mk_out(1'b0, 0, '0, 1'b1, 1'b0), 1'b0);
        send_dir("zero_plus_m2", mk_in(1'b1, 5, 60'hABC, 1'b1, 1'b1), mk_in(1'b1, 1, '0, 1'b0, 1'b0),
                 1'b1, 1'b0, mk_out(1'b1, 1, '0, 1'b0, 1'b0), 1'b0);
        send_dir("zero_trflag", one_p0, mk_in(1'b0, 0, 60'h5, 1'b0, 1'b1), 1'b0, 1'b1,
                 mk_out(1'b0, 0, '0, 1'b0, 1'b0), 1'b0);
        send_dir("both_zero", mk_in(1'b0, 0, '0, 1'b0, 1'b1), mk_in(1'b1, 3, 60'h7, 1'b0, 1'b1),
                 1'b0, 1'b0, mk_out(1'b0, 0, '0, 1'b0, 1'b1), 1'b0);
        drain();

        // Back-to-back stream with a five-cycle output stall
        pop0 = n_pop;
        fork
            begin
                for (int i = 0; i < 8; i++) drive_pair(rand_op(), rand_op(), 1'($urandom()), 1'b0);
            end
            begin
                out_ready = 1'b1;
                for (int c = 1; c <= 14; c++) begin
                    @(posedge clk); #1;
                    out_ready = !(c >= 5 && c <= 9);
                end
            end
        join
        drain();
        check("bp.count", n_pop - pop0, 8);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) drive_pair(rand_op(), rand_op(), 1'b0, 1'b0);
        rst_n = 1'b0;
        in1 = one_p0; in2 = one_p0; in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("midrst.out_valid", out_valid, 1'b0);
        check("midrst.in_ready", in_ready, 1'b1);
        check("midrst.result", result, '0);
        check("midrst.trunc", truncated, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst.no_stale", out_valid, 1'b0);
        end
        send_dir("after_rst", mk_in(1'b0, 0, F_1P5, 1'b0, 1'b0), mk_in(1'b0, 0, F_1P25, 1'b0, 1'b0),
                 1'b0, 1'b0, mk_out(1'b0, 1, 63'h3000000000000000, 1'b0, 1'b0), 1'b0);
        drain();

        // Randomized traffic with random gaps and random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    a = rand_op();
                    b = rand_op();
                    case ($urandom_range(0, 5))
                        0: b = a ^ {1'b1, {(IN_W-1){1'b0}}};
                        1: b[IN_W-2 -: SCALE_W] = a[IN_W-2 -: SCALE_W];
                        default: ;
                    endcase
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                    drive_pair(a, b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
